// File: rtl/scan_sched.sv
// rtl/scan_sched.sv - SCAN polar decoder depth-first step scheduler (option: SCAN_EARLY_STOP_EN)
module scan_sched #(
    parameter int N     = 1024,
    parameter int LOG_N = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  num_iter,
    output logic        op_valid,
    input  logic        op_ready,
`ifdef SCAN_EARLY_STOP_EN
    input  logic        early_stop,
`endif
    output logic [3:0]  u_type_w,
    output logic [10:0] layer_w,
    output logic        last_op,
    output logic [3:0]  iter_cnt,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    localparam logic [3:0]  OP_TYPE1  = 4'b0000;
    localparam logic [3:0]  OP_TYPE2  = 4'b0001;
    localparam logic [3:0]  OP_BOTTOM = 4'b0010;
    localparam logic [3:0]  OP_TYPE3  = 4'b0011;
    localparam logic [10:0] L_N       = 11'(N);

    state_t           state_q, state_d;
    logic [10:0]      l_q, l_d;
    logic [LOG_N-1:0] path_q, path_d;
    logic             asc_q, asc_d;
    logic [3:0]       iter_q, iter_d;
    logic [3:0]       last_iter_q, last_iter_d;

    logic [LOG_N-1:0] mask;
    logic             is_right;
    logic             fire;
    logic             stop;

    // Path bit of the parent level (2L) sits at index log2(L), which is L itself as a one-hot mask.
    assign mask     = l_q[LOG_N-1:0];
    assign is_right = |(path_q & mask);

    always_comb begin
        state_d     = state_q;
        l_d         = l_q;
        path_d      = path_q;
        asc_d       = asc_q;
        iter_d      = iter_q;
        last_iter_d = last_iter_q;
        op_valid    = 1'b0;
        u_type_w    = 4'b0000;
        layer_w     = 11'd0;
        last_op     = 1'b0;
        fire        = 1'b0;
        stop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    l_d         = L_N;
                    path_d      = '0;
                    asc_d       = 1'b0;
                    iter_d      = 4'd0;
                    last_iter_d = (num_iter == 4'd0) ? 4'd0 : num_iter - 4'd1;
                end
            end
            S_RUN: begin
                if (!asc_q) begin
                    op_valid = 1'b1;
                    fire     = op_ready;
                    if (l_q > 11'd2) begin
                        u_type_w = OP_TYPE1;
                        layer_w  = l_q;
                        if (fire) l_d = l_q >> 1;
                    end else begin
                        u_type_w = OP_BOTTOM;
                        layer_w  = 11'd2;
                        if (fire) asc_d = 1'b1;
                    end
                end else if (l_q != L_N) begin
                    op_valid = 1'b1;
                    fire     = op_ready;
                    layer_w  = l_q << 1;
                    if (!is_right) begin
                        u_type_w = OP_TYPE2;
                        if (fire) begin
                            path_d = path_q | mask;
                            asc_d  = 1'b0;
                        end
                    end else begin
                        u_type_w = OP_TYPE3;
                        // Closing the root's right child (size N/2) ends the iteration.
                        last_op  = path_q[LOG_N-1] && (l_q == (L_N >> 2));
                        if (fire) begin
                            path_d = path_q & ~mask;
                            l_d    = l_q << 1;
                        end
                    end
                end
                if (fire && last_op) begin
                    stop = (iter_q == last_iter_q);
`ifdef SCAN_EARLY_STOP_EN
                    stop = stop | early_stop;
`endif
                    if (stop) begin
                        state_d = S_FIN;
                    end else begin
                        iter_d = iter_q + 4'd1;
                        l_d    = L_N;
                        path_d = '0;
                        asc_d  = 1'b0;
                    end
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            l_q         <= 11'd0;
            path_q      <= '0;
            asc_q       <= 1'b0;
            iter_q      <= 4'd0;
            last_iter_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            l_q         <= l_d;
            path_q      <= path_d;
            asc_q       <= asc_d;
            iter_q      <= iter_d;
            last_iter_q <= last_iter_d;
        end
    end

    assign iter_cnt = iter_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_FIN);

endmodule
